// File: rtl/dcache_ctrl_param.sv
// Fully-associative write-through L1 data-cache controller with one request in flight.
// Define DCACHE_WRITE_ALLOCATE_EN to make store misses fill the line (merged) before the write-through.
module dcache_ctrl_param #(
    parameter int NUM_LINES  = 4,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int ITAG_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [ITAG_W-1:0]        req_itag,
    output logic                     resp_valid,
    output logic [31:0]              resp_data,
    output logic [ITAG_W-1:0]        resp_itag,
    output logic                     mem_rd_req,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic                     mem_rd_ack,
    input  logic [LINE_WORDS*32-1:0] mem_rd_data,
    output logic                     mem_wr_req,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [31:0]              mem_wr_data,
    input  logic                     mem_wr_ack
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = ADDR_W - OFF_W;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int WRD_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_WRITE} state_t;

    // Byte offset is dropped at latch time; only the word address is kept.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-3:0] waddr;
        logic [31:0]       wdata;
        logic [ITAG_W-1:0] itag;
    } req_t;

    state_t st, st_nxt;
    req_t   r;

    logic [NUM_LINES-1:0]                      line_valid;
    logic [NUM_LINES-1:0][TAG_W-1:0]           line_tag;
    logic [NUM_LINES-1:0][LINE_WORDS-1:0][31:0] line_data;
    logic [IDX_W-1:0]                          victim_ptr;

    logic [TAG_W-1:0]                 r_tag;
    logic [WRD_W-1:0]                 r_word;
    logic [NUM_LINES-1:0]             hit_vec;
    logic                             hit;
    logic [IDX_W-1:0]                 hit_idx;
    logic [IDX_W-1:0]                 victim_idx;
    logic                             any_inv;
    logic [LINE_WORDS-1:0][31:0]      fill_line;
    logic                             unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];
    assign r_tag  = r.waddr[ADDR_W-3:OFF_W-2];
    assign r_word = r.waddr[OFF_W-3:0];

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_cmp
        assign hit_vec[g] = line_valid[g] && (line_tag[g] == r_tag);
    end
    assign hit = |hit_vec;

    // Tags are unique, so at most one hit bit is set.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < NUM_LINES; i++)
            if (hit_vec[i]) hit_idx = IDX_W'(i);
    end

    // Lowest-index invalid line wins; otherwise round-robin pointer.
    always_comb begin
        victim_idx = victim_ptr;
        any_inv    = 1'b0;
        for (int i = NUM_LINES - 1; i >= 0; i--)
            if (!line_valid[i]) begin
                victim_idx = IDX_W'(i);
                any_inv    = 1'b1;
            end
    end

    always_comb begin
        fill_line = mem_rd_data;
`ifdef DCACHE_WRITE_ALLOCATE_EN
        if (r.we) fill_line[r_word] = r.wdata;
`endif
    end

    always_comb begin
        st_nxt      = st;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_itag   = '0;
        mem_rd_req  = 1'b0;
        mem_rd_addr = '0;
        mem_wr_req  = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        case (st)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) st_nxt = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (!r.we) begin
                    if (hit) begin
                        resp_valid = 1'b1;
                        resp_data  = line_data[hit_idx][r_word];
                        resp_itag  = r.itag;
                        st_nxt     = S_IDLE;
                    end else begin
                        st_nxt = S_FILL;
                    end
                end else begin
`ifdef DCACHE_WRITE_ALLOCATE_EN
                    st_nxt = hit ? S_WRITE : S_FILL;
`else
                    st_nxt = S_WRITE;
`endif
                end
            end
            S_FILL: begin
                mem_rd_req  = 1'b1;
                mem_rd_addr = {r_tag, {OFF_W{1'b0}}};
                if (mem_rd_ack) begin
                    if (r.we) begin
                        st_nxt = S_WRITE;
                    end else begin
                        resp_valid = 1'b1;
                        resp_data  = fill_line[r_word];
                        resp_itag  = r.itag;
                        st_nxt     = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                mem_wr_req  = 1'b1;
                mem_wr_addr = {r.waddr, 2'b00};
                mem_wr_data = r.wdata;
                if (mem_wr_ack) st_nxt = S_IDLE;
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            r          <= '0;
            line_valid <= '0;
            victim_ptr <= '0;
        end else begin
            st <= st_nxt;
            if (st == S_IDLE && req_valid)
                r <= '{we: req_we, waddr: req_addr[ADDR_W-1:2], wdata: req_wdata, itag: req_itag};
            if (st == S_FILL && mem_rd_ack) begin
                line_valid[victim_idx] <= 1'b1;
                if (!any_inv) victim_ptr <= victim_ptr + IDX_W'(1);
            end
        end
    end

    // Line payload carries no reset; a reset cycle still blocks every write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (st == S_LOOKUP && r.we && hit)
                line_data[hit_idx][r_word] <= r.wdata;
            if (st == S_FILL && mem_rd_ack) begin
                line_data[victim_idx] <= fill_line;
                line_tag[victim_idx]  <= r_tag;
            end
        end
    end
endmodule

// File: tb/tb_dcache_ctrl_param.sv
// Directed bench for dcache_ctrl_param: fills, hits, eviction order, stores, reset abort, back-to-back.
module tb_dcache_ctrl_param;
    localparam int NL = 4;
    localparam int LW = 4;
    localparam int AW = 32;
    localparam int TW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [TW-1:0]   req_itag = '0;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic [TW-1:0]   resp_itag;
    logic            mem_rd_req;
    logic [AW-1:0]   mem_rd_addr;
    logic            mem_rd_ack = 1'b0;
    logic [LW*32-1:0] mem_rd_data = '0;
    logic            mem_wr_req;
    logic [AW-1:0]   mem_wr_addr;
    logic [31:0]     mem_wr_data;
    logic            mem_wr_ack = 1'b0;

    dcache_ctrl_param #(.NUM_LINES(NL), .LINE_WORDS(LW), .ADDR_W(AW), .ITAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_itag(req_itag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_itag(resp_itag),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ack(mem_wr_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rd_dly = 0;
    int rd_wait = 0;
    int wr_wait = 0;
    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, acc_cnt = 0, rd_req_cyc = 0, overlap = 0;
    int acc_cyc = 0, resp_cyc = 0;
    logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
    logic [31:0] last_data = '0, prev_data = '0, last_itag = '0, prev_itag = '0;
    logic [31:0] mem_m [logic [31:0]];

    // Backing store: untouched words follow a fixed address pattern.
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return 32'hAAAA0000 + a - 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: reacts to post-edge request state.
    initial forever begin
        @(posedge clk); #2;
        if (mem_rd_req) begin
            if (rd_wait >= rd_dly) begin
                mem_rd_ack = 1'b1;
                for (int i = 0; i < LW; i++) mem_rd_data[i*32 +: 32] = rd_word(mem_rd_addr + 32'(4*i));
                rd_cnt++;
                last_rd_addr = mem_rd_addr;
                rd_wait = 0;
            end else begin
                mem_rd_ack = 1'b0;
                rd_wait++;
            end
        end else begin
            mem_rd_ack = 1'b0;
            rd_wait = 0;
        end
        if (mem_wr_req) begin
            if (wr_wait >= 1) begin
                mem_wr_ack = 1'b1;
                mem_m[mem_wr_addr] = mem_wr_data;
                wr_cnt++;
                last_wr_addr = mem_wr_addr;
                last_wr_data = mem_wr_data;
                wr_wait = 0;
            end else begin
                mem_wr_ack = 1'b0;
                wr_wait++;
            end
        end else begin
            mem_wr_ack = 1'b0;
            wr_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
        if (resp_valid) begin
            resp_cnt++; resp_cyc = cyc;
            prev_data = last_data; prev_itag = last_itag;
            last_data = resp_data; last_itag = resp_itag;
        end
        if (mem_rd_req) rd_req_cyc++;
        if (mem_rd_req && mem_wr_req) overlap++;
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [31:0] it);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_itag = it;
        wait_idle();
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    int r0, w0, p0, a0, q0, busy;

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rd_req", mem_rd_req, 0);
        chk("rst_wr_req", mem_wr_req, 0);
        chk("rst_outs_zero", {resp_data, resp_itag, mem_rd_addr, mem_wr_addr, mem_wr_data}, 0);

        // Miss then hit on 0x100
        rd_dly = 3;
        r0 = rd_cnt; p0 = resp_cnt;
        do_req(0, 32'h100, 0, 5);
        chk("miss_rd_cnt", rd_cnt - r0, 1);
        chk("miss_rd_addr", last_rd_addr, 32'h100);
        chk("miss_resp_cnt", resp_cnt - p0, 1);
        chk("miss_resp_data", last_data, 32'hAAAA0000);
        chk("miss_resp_itag", last_itag, 5);
        r0 = rd_cnt; p0 = resp_cnt;
        do_req(0, 32'h100, 0, 6);
        chk("hit_no_fill", rd_cnt - r0, 0);
        chk("hit_resp_cnt", resp_cnt - p0, 1);
        chk("hit_latency", resp_cyc - acc_cyc + 1, 2);
        chk("hit_data", last_data, 32'hAAAA0000);
        chk("hit_itag", last_itag, 6);

        // Replacement order from an empty cache
        do_reset();
        rd_dly = 1;
        do_req(0, 32'h000, 0, 1);
        do_req(0, 32'h010, 0, 2);
        do_req(0, 32'h020, 0, 3);
        do_req(0, 32'h030, 0, 4);
        r0 = rd_cnt;
        do_req(0, 32'h040, 0, 7);
        chk("evict_fill", rd_cnt - r0, 1);
        chk("evict_data", last_data, 32'hAAAA0000 + 32'h40 - 32'h100);
        r0 = rd_cnt;
        do_req(0, 32'h010, 0, 8);
        chk("line1_kept", rd_cnt - r0, 0);
        r0 = rd_cnt;
        do_req(0, 32'h000, 0, 9);
        chk("line0_evicted", rd_cnt - r0, 1);
        r0 = rd_cnt;
        do_req(0, 32'h010, 0, 10);
        chk("line1_evicted", rd_cnt - r0, 1);
        r0 = rd_cnt;
        do_req(0, 32'h030, 0, 11);
        chk("line3_kept", rd_cnt - r0, 0);

        // Store hit with write-through
        do_req(0, 32'h100, 0, 12);
        r0 = rd_cnt; w0 = wr_cnt; p0 = resp_cnt;
        do_req(1, 32'h104, 32'hDEADBEEF, 13);
        chk("st_wr_cnt", wr_cnt - w0, 1);
        chk("st_wr_addr", last_wr_addr, 32'h104);
        chk("st_wr_data", last_wr_data, 32'hDEADBEEF);
        chk("st_no_resp", resp_cnt - p0, 0);
        chk("st_no_fill", rd_cnt - r0, 0);
        r0 = rd_cnt;
        do_req(0, 32'h104, 0, 14);
        chk("st_hit_no_fill", rd_cnt - r0, 0);
        chk("st_hit_data", last_data, 32'hDEADBEEF);

        // Store miss
        r0 = rd_cnt; w0 = wr_cnt; p0 = resp_cnt;
        do_req(1, 32'h200, 32'h12345678, 15);
        chk("stm_wr_cnt", wr_cnt - w0, 1);
        chk("stm_wr_addr", last_wr_addr, 32'h200);
        chk("stm_no_resp", resp_cnt - p0, 0);
`ifdef DCACHE_WRITE_ALLOCATE_EN
        chk("stm_fill", rd_cnt - r0, 1);
        r0 = rd_cnt;
        do_req(0, 32'h200, 0, 16);
        chk("stm_load_hit", rd_cnt - r0, 0);
`else
        chk("stm_fill", rd_cnt - r0, 0);
        r0 = rd_cnt;
        do_req(0, 32'h200, 0, 16);
        chk("stm_load_miss", rd_cnt - r0, 1);
`endif
        chk("stm_load_data", last_data, 32'h12345678);

        // Reset during a pending fill
        rd_dly = 20;
        r0 = rd_cnt; p0 = resp_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_itag = 17;
        wait_idle();
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_fill_pending", mem_rd_req, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("abort_rd_req", mem_rd_req, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_resp", resp_valid, 0);
        chk("abort_no_resp", resp_cnt - p0, 0);
        chk("abort_no_ack", rd_cnt - r0, 0);
        rd_dly = 0;
        r0 = rd_cnt;
        do_req(0, 32'h100, 0, 18);
        chk("abort_line_lost", rd_cnt - r0, 1);
        chk("abort_refill_data", last_data, 32'hAAAA0000);

        // Ack in first fill cycle with req_valid held through the busy period
        a0 = acc_cnt; p0 = resp_cnt; q0 = rd_req_cyc; busy = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h400; req_itag = 20;
        @(negedge clk);
        @(posedge clk); #1;
        req_addr = 32'h100; req_itag = 21;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) break;
            busy++;
        end
        @(posedge clk); #1; req_valid = 1'b0;
        wait_idle();
        chk("b2b_busy_cycles", busy, 2);
        chk("b2b_fill_cycles", rd_req_cyc - q0, 1);
        chk("b2b_accepts", acc_cnt - a0, 2);
        chk("b2b_resps", resp_cnt - p0, 2);
        chk("b2b_first_itag", prev_itag, 20);
        chk("b2b_first_data", prev_data, 32'hAAAA0300);
        chk("b2b_second_itag", last_itag, 21);
        chk("b2b_second_data", last_data, 32'hAAAA0000);

        chk("no_rd_wr_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
